// File: rtl/token_share_scheduler.sv
// ============================================================================
// Module   : token_share_scheduler
// Brief    : N serial token sources, per-source divide-by-R reducers and
//            credit queues, round-robin merged onto one token line with ID.
//            Optional TOKEN_SCHED_READY_EN adds b_ready backpressure.
// Revision : 1.0
// ============================================================================
`default_nettype none

module token_share_scheduler #(
  parameter int N      = 4,
  parameter int CNT_W  = 4,
  parameter int PEND_W = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         a,
  input  logic                 cfg_we,
  input  logic [$clog2(N)-1:0] cfg_sel,
  input  logic [CNT_W-1:0]     cfg_ratio,
`ifdef TOKEN_SCHED_READY_EN
  input  logic                 b_ready,
`endif
  output logic                 b,
  output logic [$clog2(N)-1:0] b_id,
  output logic [N-1:0]         ovf
);

  localparam int              c_id_w     = $clog2(N);
  localparam logic [PEND_W-1:0] c_pend_max = '1;

  logic [CNT_W-1:0]  r_ratio [N];
  logic [CNT_W-1:0]  r_div   [N];
  logic [PEND_W-1:0] r_pend  [N];
  logic [N-1:0]      r_ovf;
  logic [c_id_w-1:0] r_ptr;
  logic              r_b;
  logic [c_id_w-1:0] r_b_id;

  logic [N-1:0]      w_wr;
  logic [N-1:0]      w_credit;
  logic [N-1:0]      w_req;
  logic [N-1:0]      w_gnt;
  logic              w_stall;
  logic              w_gnt_vld;
  logic [c_id_w-1:0] w_gnt_id;

  // A held output token blocks new grants until the consumer takes it.
`ifdef TOKEN_SCHED_READY_EN
  assign w_stall = r_b && !b_ready;
`else
  assign w_stall = 1'b0;
`endif

  always_comb begin
    w_wr     = '0;
    w_credit = '0;
    w_req    = '0;
    for (int i = 0; i < N; i++) begin
      w_wr[i]     = cfg_we && (cfg_sel == c_id_w'(i));
      w_credit[i] = a[i] && !w_wr[i] && (r_ratio[i] != '0) &&
                    ((r_div[i] + CNT_W'(1)) == r_ratio[i]);
      w_req[i]    = (r_pend[i] != '0);
    end
  end

  // Round-robin search starting just after the last granted source.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_id  = r_ptr;
    for (int k = 1; k <= N; k++) begin
      int unsigned idx;
      idx = (int'(r_ptr) + k) % N;
      if (!w_gnt_vld && !w_stall && w_req[idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt_id  = c_id_w'(idx);
      end
    end
  end

  always_comb begin
    w_gnt = '0;
    for (int i = 0; i < N; i++) begin
      w_gnt[i] = w_gnt_vld && (w_gnt_id == c_id_w'(i));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        r_ratio[i] <= CNT_W'(2);
        r_div[i]   <= '0;
        r_pend[i]  <= '0;
      end
      r_ovf <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (w_wr[i]) begin
          r_ratio[i] <= cfg_ratio;
          r_div[i]   <= '0;
          r_ovf[i]   <= 1'b0;
        end else if (a[i] && (r_ratio[i] != '0)) begin
          r_div[i] <= w_credit[i] ? '0 : r_div[i] + CNT_W'(1);
        end
        // Credit queue kept across config writes; a lost credit sets ovf.
        case ({w_credit[i], w_gnt[i]})
          2'b10: begin
            if (r_pend[i] == c_pend_max) r_ovf[i] <= 1'b1;
            else                          r_pend[i] <= r_pend[i] + PEND_W'(1);
          end
          2'b01:   r_pend[i] <= r_pend[i] - PEND_W'(1);
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr  <= c_id_w'(N - 1);
      r_b    <= 1'b0;
      r_b_id <= '0;
    end else begin
      if (w_gnt_vld) r_ptr <= w_gnt_id;
      if (!w_stall) begin
        r_b <= w_gnt_vld;
        if (w_gnt_vld) r_b_id <= w_gnt_id;
      end
    end
  end

  assign b    = r_b;
  assign b_id = r_b_id;
  assign ovf  = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_token_share_scheduler.sv
// ============================================================================
// Module   : tb_token_share_scheduler
// Brief    : Directed and randomized stimulus against a behavioural model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_token_share_scheduler;

  localparam int N      = 4;
  localparam int CNT_W  = 4;
  localparam int PEND_W = 3;
  localparam int IDW    = $clog2(N);
  localparam int PMAX   = (1 << PEND_W) - 1;

  logic           clk;
  logic           rst;
  logic [N-1:0]   a;
  logic           cfg_we;
  logic [IDW-1:0] cfg_sel;
  logic [CNT_W-1:0] cfg_ratio;
  logic           b_ready;
  logic           b;
  logic [IDW-1:0] b_id;
  logic [N-1:0]   ovf;

  int n_cmp = 0;
  int n_err = 0;

  token_share_scheduler #(.N(N), .CNT_W(CNT_W), .PEND_W(PEND_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .cfg_we    (cfg_we),
    .cfg_sel   (cfg_sel),
    .cfg_ratio (cfg_ratio),
`ifdef TOKEN_SCHED_READY_EN
    .b_ready   (b_ready),
`endif
    .b         (b),
    .b_id      (b_id),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integer bookkeeping of the token/credit rules.
  int m_ratio [N];
  int m_div   [N];
  int m_pend  [N];
  int m_ovf   [N];
  int m_ptr, m_b, m_bid;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_ratio[i] = 2; m_div[i] = 0; m_pend[i] = 0; m_ovf[i] = 0;
    end
    m_ptr = N - 1; m_b = 0; m_bid = 0;
  endfunction

  function automatic logic [N-1:0] model_ovf();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = (m_ovf[i] != 0);
    return v;
  endfunction

  function automatic void model_step(input logic [N-1:0] av, input logic we,
                                     input int sel, input int rat, input logic rdy);
    bit stall = 0;
    int g = -1;
`ifdef TOKEN_SCHED_READY_EN
    stall = (m_b != 0) && !rdy;
`endif
    if (!stall)
      for (int k = 1; k <= N; k++) begin
        int j = (m_ptr + k) % N;
        if (g < 0 && m_pend[j] > 0) g = j;
      end
    for (int i = 0; i < N; i++) begin
      bit wr = we && (sel == i);
      bit cr = av[i] && !wr && m_ratio[i] != 0 && (m_div[i] + 1 == m_ratio[i]);
      int p;
      if (wr) begin
        m_ratio[i] = rat; m_div[i] = 0; m_ovf[i] = 0;
      end else if (av[i] && m_ratio[i] != 0) begin
        m_div[i] = cr ? 0 : m_div[i] + 1;
      end
      p = m_pend[i] + int'(cr) - int'(g == i);
      if (p > PMAX) begin
        p = PMAX; m_ovf[i] = 1;
      end
      m_pend[i] = p;
    end
    if (!stall) begin
      m_b = (g >= 0) ? 1 : 0;
      if (g >= 0) begin
        m_bid = g; m_ptr = g;
      end
    end
  endfunction

  // One clock: compare at the falling edge, then apply the next inputs.
  task automatic cycle(input logic [N-1:0] av, input logic we, input int sel,
                       input int rat, input logic rdy);
    @(negedge clk);
    check("b", 32'(b), 32'(m_b));
    check("b_id", 32'(b_id), 32'(m_bid));
    check("ovf", 32'(ovf), 32'(model_ovf()));
    a = av; cfg_we = we; cfg_sel = IDW'(sel); cfg_ratio = CNT_W'(rat); b_ready = rdy;
    model_step(av, we, sel, rat, rdy);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle('0, 1'b0, 0, 0, 1'b1);
  endtask

  task automatic cfg(input int sel, input int rat);
    cycle('0, 1'b1, sel, rat, 1'b1);
  endtask

  initial begin
    rst = 1'b0; a = '0; cfg_we = 1'b0; cfg_sel = '0; cfg_ratio = '0; b_ready = 1'b1;
    model_reset();
    #12;
    check("rst_b", 32'(b), 32'd0);
    check("rst_b_id", 32'(b_id), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Default ratio 2 on source 0
    for (int k = 0; k < 4; k++) cycle(4'b0001, 1'b0, 0, 0, 1'b1);
    idle(5);

    // Ratio 3 on source 1, then disable it
    cfg(1, 3);
    for (int k = 0; k < 9; k++) cycle(4'b0010, 1'b0, 0, 0, 1'b1);
    idle(4);
    cfg(1, 0);
    for (int k = 0; k < 5; k++) cycle(4'b0010, 1'b0, 0, 0, 1'b1);
    idle(4);

    // All sources at ratio 1, one burst
    for (int s = 0; s < N; s++) cfg(s, 1);
    cycle(4'b1111, 1'b0, 0, 0, 1'b1);
    idle(6);

    // Saturate source 2, clear its flag by a write, then drain
    for (int k = 0; k < 20; k++) cycle(4'b0100 | 4'($urandom), 1'b0, 0, 0, 1'b1);
    cfg(2, 1);
    idle(14);

    // Config write coinciding with a token on source 0
    cfg(0, 2);
    cycle(4'b0001, 1'b0, 0, 0, 1'b1);
    cycle(4'b0001, 1'b1, 0, 2, 1'b1);
    cycle(4'b0001, 1'b0, 0, 0, 1'b1);
    cycle(4'b0001, 1'b0, 0, 0, 1'b1);
    idle(4);

    // Backpressure hold then release (ready ignored in the default build)
    for (int s = 0; s < N; s++) cfg(s, 1);
    cycle(4'b1111, 1'b0, 0, 0, 1'b1);
    for (int k = 0; k < 5; k++) cycle('0, 1'b0, 0, 0, 1'b0);
    for (int k = 0; k < 8; k++) cycle('0, 1'b0, 0, 0, 1'b1);

    // Randomized traffic with occasional reconfiguration
    for (int k = 0; k < 400; k++)
      cycle(4'($urandom), ($urandom_range(15) == 0), $urandom_range(N - 1),
            $urandom_range(5), ($urandom_range(3) != 0));
    idle(10);

    // Heavy load into overflow, then asynchronous reset mid-cycle
    for (int s = 0; s < N; s++) cfg(s, 1);
    for (int k = 0; k < 16; k++) cycle(4'b1111, 1'b0, 0, 0, 1'b1);
    @(negedge clk);
    a = '0;
    #2 rst = 1'b0;
    #1;
    check("async_b", 32'(b), 32'd0);
    check("async_ovf", 32'(ovf), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    idle(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/token_share_scheduler.md
# token_share_scheduler

Shares one serial token output line between N serial token sources. Each source gets a programmable divide-by-R token reducer; reset default R=2 halves the stream. Reduced tokens queue as per-source credits, and a round-robin arbiter drains them one token per cycle onto the shared line with a source ID. It sits downstream of the serial token generators and upstream of a single-token consumer.

## Interface
- N, 4, number of token sources (2..8)
- CNT_W, 4, width of ratio and divider counters
- PEND_W, 3, width of per-source pending-credit counters
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- a  in  N  serial tokens; bit i high = one token from source i this cycle
- cfg_we  in  1  write ratio for source cfg_sel
- cfg_sel  in  $clog2(N)  source index for the write
- cfg_ratio  in  CNT_W  tokens in per credit out; 0 = source disabled
- b  out  1  shared output token
- b_id  out  $clog2(N)  source of the token on b; valid when b=1
- ovf  out  N  sticky per-source credit-overflow flags

## Operation
- Per-source state:
  - ratio[i], reset 2
  - div[i], reset 0
  - pend[i], reset 0
  - ovf[i], reset 0
- Divider, when a[i]=1 and ratio[i]≠0:
  - if div[i]+1 == ratio[i]: div[i]←0 and one credit is generated
  - else: div[i]←div[i]+1
- ratio[i]=0: tokens are dropped and div[i] holds.
- ratio[i]=1: every token becomes a credit.
- Pending credits:
  - pend[i] ← pend[i] + credit − grant.
  - Credit and grant in the same cycle leave pend[i] unchanged.
  - Credit with pend[i] = 2^PEND_W−1 and no grant: credit is lost, pend[i] stays saturated, ovf[i]←1.
- Arbiter:
  - Requesting set is every i with pend[i]>0, evaluated from registered state.
  - Search starts at ptr+1 mod N and grants the first requesting source.
  - On a grant, ptr←granted index. ptr resets to N−1, so source 0 wins first.
  - At most one grant per cycle.
- Output: b and b_id are registered from the grant. With no grant, b=0 and b_id holds its last value.
- Config write on cfg_sel=k:
  - ratio[k]←cfg_ratio, div[k]←0, ovf[k]←0.
  - pend[k] is kept, so queued credits still drain.
  - A token on a[k] in the write cycle is discarded.
- All arithmetic is unsigned. div and ratio compare at CNT_W bits, with no wrap beyond ratio.

## Timing
- Reset (async assert, sync deassert to clk): all state takes the values above; b=0, b_id=0, ovf=0.
- Reset asserted mid-operation aborts all pending credits immediately.
- Latency: a token completing a ratio in cycle c gives pend>0 in cycle c+1. If it wins arbitration, b=1 in cycle c+2.
- Throughput: one output token per cycle in aggregate. With K sources continuously requesting, each gets 1 of every K cycles.
- Simultaneous credit and grant on the same source is legal. Sustained 1/cycle per source at ratio 1 is lossless only when that source is alone.

## Configuration
- TOKEN_SCHED_READY_EN adds input port b_ready (1 bit).
- With TOKEN_SCHED_READY_EN:
  - Once b=1, b and b_id hold until a cycle with b_ready=1.
  - No new grant is issued while b=1 and b_ready=0.
  - On acceptance, the next grant can appear in the following cycle (no bubble).
  - Credits keep accumulating while stalled and may overflow.
- Without it: no b_ready port, and every b=1 cycle is consumed.

## Test plan
- Reset defaults, N=4, a[0]=1 for 4 cycles, others 0 → b pulses twice, b_id=0, first pulse 2 cycles after the 2nd token; ovf=0.
- ratio[1]=3, a[1]=1 for 9 cycles → exactly 3 pulses with b_id=1. Then write ratio[1]=0, drive 5 more tokens → no further pulses.
- All four sources at ratio 1, a=4'b1111 for 1 cycle → b high for 4 consecutive cycles, b_id=0,1,2,3.
- Source 2 at ratio 1, a[2]=1 continuously, other sources also active → pend[2] reaches 7, then ovf[2]=1. A config write to source 2 clears ovf[2], and the 7 credits still drain.
- Config write to source 0 in the same cycle as a[0]=1, with div[0]=1 before the write → that token is ignored and div[0]=0. The next 2 tokens give 1 pulse.
- TOKEN_SCHED_READY_EN defined, b_ready=0 for 5 cycles with credits queued → b=1 with b_id stable for those cycles. Raise b_ready → one token accepted per cycle in round-robin order.
- rst asserted while pend is nonzero → b=0 and all pend/ovf/div cleared without waiting for a clock edge.
